// File: rtl/sprite_addr_gen_pkg.sv
// Shared sprite-renderer types and default geometry.
// Derived widths below follow the default geometry; blocks recompute them from their own parameters.
package sprite_pkg;
  localparam int DEF_SPR_W       = 64;
  localparam int DEF_SPR_H       = 128;
  localparam int DEF_N_FRAMES    = 4;
  localparam int DEF_FRAME_TICKS = 6;
  localparam int DEF_COORD_W     = 10;
  localparam int DEF_ADDR_W      = 16;

  localparam int COL_W = $clog2(DEF_SPR_W);
  localparam int ROW_W = $clog2(DEF_SPR_H);
  localparam int FRM_W = $clog2(DEF_N_FRAMES);

  typedef enum logic {IDLE, PLAY} anim_state_t;
endpackage

// File: rtl/sprite_addr_gen_if.sv
// Pixel/position inputs and ROM-address/animation outputs of the sprite address generator.
interface sprite_addr_gen_if #(
  parameter int COORD_W = sprite_pkg::DEF_COORD_W,
  parameter int ADDR_W  = sprite_pkg::DEF_ADDR_W,
  parameter int FRM_W   = sprite_pkg::FRM_W
);
  logic [COORD_W-1:0] i_draw_x;
  logic [COORD_W-1:0] i_draw_y;
  logic               i_frame_start;
  logic [COORD_W-1:0] i_pos_x;
  logic [COORD_W-1:0] i_pos_y;
  logic               i_flip;
  logic               i_play;
  logic               i_loop;
  logic [ADDR_W-1:0]  o_rom_address;
  logic               o_sprite_on;
  logic [FRM_W-1:0]   o_frame_idx;
  logic               o_busy;
  logic               o_done;

  modport slave (
    input  i_draw_x, i_draw_y, i_frame_start, i_pos_x, i_pos_y, i_flip, i_play, i_loop,
    output o_rom_address, o_sprite_on, o_frame_idx, o_busy, o_done
  );

  modport master (
    output i_draw_x, i_draw_y, i_frame_start, i_pos_x, i_pos_y, i_flip, i_play, i_loop,
    input  o_rom_address, o_sprite_on, o_frame_idx, o_busy, o_done
  );
endinterface

// File: rtl/sprite_addr_gen_anim_seq.sv
// Animation sequencer: advances the sprite frame only on frame_start so a frame never tears.
module anim_seq
  import sprite_pkg::*;
#(
  parameter int N_FRAMES    = DEF_N_FRAMES,
  parameter int FRAME_TICKS = DEF_FRAME_TICKS,
  localparam int FRM_BITS   = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
  localparam int TICK_BITS  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_frame_start,
  input  logic                i_play,
  input  logic                i_loop,
  output logic [FRM_BITS-1:0] o_frame_idx,
  output logic                o_busy,
  output logic                o_done
);
  localparam logic [TICK_BITS-1:0] LAST_TICK  = TICK_BITS'(FRAME_TICKS - 1);
  localparam logic [FRM_BITS-1:0]  LAST_FRAME = FRM_BITS'(N_FRAMES - 1);

  anim_state_t          r_state;
  logic [TICK_BITS-1:0] r_tick;
  logic [FRM_BITS-1:0]  r_frame_idx;
  logic                 r_busy;
  logic                 r_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_tick      <= '0;
      r_frame_idx <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // A frame_start coinciding with play is deliberately not counted.
          if (i_play) begin
            r_state     <= PLAY;
            r_busy      <= 1'b1;
            r_tick      <= '0;
            r_frame_idx <= '0;
          end
        end
        PLAY: begin
          if (i_frame_start) begin
            if (r_tick == LAST_TICK) begin
              r_tick <= '0;
              if (r_frame_idx != LAST_FRAME) begin
                r_frame_idx <= r_frame_idx + 1'b1;
              end else if (i_loop) begin
                r_frame_idx <= '0;
              end else begin
                r_state     <= IDLE;
                r_busy      <= 1'b0;
                r_frame_idx <= '0;
                r_done      <= 1'b1;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_frame_idx = r_frame_idx;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
endmodule

// File: rtl/sprite_addr_gen.sv
// Sprite ROM address pipeline: one-cycle registered address and in-sprite flag from the draw position.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPR_W       = DEF_SPR_W,
  parameter int SPR_H       = DEF_SPR_H,
  parameter int N_FRAMES    = DEF_N_FRAMES,
  parameter int FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic             i_vga_clk,
  input  logic             i_reset,
  sprite_addr_gen_if.slave bus
);
  localparam int COL_BITS = $clog2(SPR_W);
  localparam int ROW_BITS = $clog2(SPR_H);
  localparam int FRM_BITS = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

  logic [COORD_W:0]    w_dx;
  logic [COORD_W:0]    w_dy;
  logic                w_inside;
  logic [COL_BITS-1:0] w_col;
  logic [ADDR_W-1:0]   w_addr;
  logic [FRM_BITS-1:0] w_frame_idx;
  logic                w_busy;
  logic                w_done;
  logic [ADDR_W-1:0]   r_rom_address;
  logic                r_sprite_on;

  anim_seq #(
    .N_FRAMES    (N_FRAMES),
    .FRAME_TICKS (FRAME_TICKS)
  ) u_anim_seq (
    .i_clk         (i_vga_clk),
    .i_reset       (i_reset),
    .i_frame_start (bus.i_frame_start),
    .i_play        (bus.i_play),
    .i_loop        (bus.i_loop),
    .o_frame_idx   (w_frame_idx),
    .o_busy        (w_busy),
    .o_done        (w_done)
  );

  // One extra bit keeps the difference signed, so a sprite near the right edge cannot wrap into a hit.
  assign w_dx = {1'b0, bus.i_draw_x} - {1'b0, bus.i_pos_x};
  assign w_dy = {1'b0, bus.i_draw_y} - {1'b0, bus.i_pos_y};

  assign w_inside = !w_dx[COORD_W] && !w_dy[COORD_W]
                    && (w_dx[COORD_W-1:0] < COORD_W'(SPR_W))
                    && (w_dy[COORD_W-1:0] < COORD_W'(SPR_H));

  // SPR_W is a power of two, so SPR_W-1-dx is the bitwise complement of the column bits.
  assign w_col  = bus.i_flip ? ~w_dx[COL_BITS-1:0] : w_dx[COL_BITS-1:0];
  assign w_addr = ADDR_W'({w_frame_idx, w_dy[ROW_BITS-1:0], w_col});

  always_ff @(posedge i_vga_clk) begin
    if (i_reset) begin
      r_rom_address <= '0;
      r_sprite_on   <= 1'b0;
    end else begin
      r_rom_address <= w_inside ? w_addr : '0;
      r_sprite_on   <= w_inside;
    end
  end

  assign bus.o_rom_address = r_rom_address;
  assign bus.o_sprite_on   = r_sprite_on;
  assign bus.o_frame_idx   = w_frame_idx;
  assign bus.o_busy        = w_busy;
  assign bus.o_done        = w_done;
endmodule
